hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
- Registered hazard-detection and forwarding controller for the pipelined core, parametrised in register-address width and source-operand count.
- Tracks in-flight destination registers through EX, MEM and WB in its own shadow pipeline.
- Resolves forwarding for the instruction in ID one cycle ahead, so the EX-stage operand muxes get registered select lines.
- Detects load-use hazards, issues a one-cycle ID stall, and inserts a bubble into EX; supports pipeline flush.

Parameters:
ADDR_W, 5, register-address width in bits
NUM_SRC, 2, number of source operands per instruction (1..4)
NO_FWD_REG, 31, register index that never forwards or stalls

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  valid instruction in ID
id_src  input  NUM_SRC*ADDR_W  ID source register indices; operand i at bits [i*ADDR_W +: ADDR_W]
id_dst  input  ADDR_W  ID destination register
id_regwrite  input  1  ID instruction writes register file
id_memread  input  1  ID instruction is a load
flush  input  1  discard the ID instruction this cycle (branch taken)
stall_id  output  1  combinational; hold PC and IF/ID this cycle
fwd_sel  output  NUM_SRC*2  registered EX operand select per source: 00 regfile, 10 MEM result, 01 WB result
ex_bubble  output  1  registered; EX holds an inserted bubble
stall_cnt  output  16  load-use stall count (STALL_CNT_EN only, else tied 0)

Behaviour:
- Internal state:
  - EX entry {vld, dst, rw, mr}.
  - MEM entry {vld, dst, rw}.
  - fwd_sel register.
  - ex_bubble register.
- Reset (rst=1 at clock edge): all entry vld=0, fwd_sel=0, ex_bubble=0, stall_cnt=0. Reset applies mid-stall and mid-flush; stall_id is 0 in the first cycle after reset.
- Match for source i against an entry: entry.vld && entry.rw && entry.dst==src_i && entry.dst!=NO_FWD_REG.
- stall_id = id_valid && !flush && (some source i matches the EX entry, and the EX entry has mr=1). Sources with src_i==NO_FWD_REG never stall.
- Every cycle, MEM entry <= EX entry (pipeline never halts below ID).
- Normal advance (not stall, not flush):
  - EX entry <= {id_valid, id_dst, id_regwrite, id_memread}.
  - ex_bubble <= !id_valid.
  - fwd_sel[i] <= 10 if src_i matches the current EX entry (it will be in MEM next cycle).
  - Otherwise fwd_sel[i] <= 01 if src_i matches the current MEM entry (it will be in WB).
  - Otherwise fwd_sel[i] <= 00.
  - Priority: the younger producer (EX) always wins over MEM when both match.
- Stall cycle:
  - EX entry <= bubble (vld=0) and ex_bubble <= 1.
  - All fwd_sel <= 00.
  - The ID instruction is re-evaluated next cycle. The load is then in MEM, so forwarding resolves to 01 and no second stall occurs.
- Flush cycle: EX entry <= bubble, ex_bubble <= 1, fwd_sel <= 00, stall_id forced 0. Flush wins over stall.
- id_valid=0: no stall; EX gets a bubble.
- Latency: fwd_sel valid exactly one cycle after the instruction is accepted from ID (accepted means id_valid && !stall_id && !flush).
- A load followed by a dependent instruction two slots later: no stall, fwd_sel=01.
- Each source is evaluated independently; a stall caused by any source stalls the whole instruction.

Optional Feature:
STALL_CNT_EN
- Defined: 16-bit stall_cnt increments on every cycle with stall_id=1. It saturates at 16'hFFFF and is cleared by rst.
- Undefined: counter logic is absent and stall_cnt is driven constant 0.

Test Plan:
- Load-use stall: ID has rs=3, EX entry is a load writing 3 with vld=1 -> stall_id=1 that cycle, next cycle ex_bubble=1 and fwd_sel=00. After re-issue, fwd_sel[0]=01 with no further stall; stall_cnt=1 when STALL_CNT_EN is defined.
- Back-to-back ALU dependency: EX writes 5 (non-load), ID has rs=5, rt=5 -> stall_id=0, next cycle fwd_sel={10,10}.
- Priority: EX and MEM both write 7, ID rs=7 -> fwd_sel[0]=10. The same case with the EX entry invalid -> 01.
- Excluded register: EX is a load writing 31, ID rs=31 -> stall_id=0, fwd_sel=00. An ALU op writing 31 likewise gives 00.
- Flush with pending load-use: hazard present and flush=1 -> stall_id=0, next cycle ex_bubble=1 and EX entry invalid. A following instruction reading the flushed dst gets 00.
- Reset mid-stall: rst=1 asserted during a stall cycle -> next cycle fwd_sel=0, ex_bubble=0, stall_id=0 with id_valid held, stall_cnt=0.
- Parametrisation: NUM_SRC=3, ADDR_W=6, third source 40 matches MEM dst 40 -> fwd_sel[5:4]=01.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: registered hazard detection and operand-forwarding
// control. A shadow pipeline (EX and MEM entries) tracks the destination
// registers of in-flight instructions. Forwarding for the instruction in ID
// is resolved one cycle early, so the EX-stage operand muxes are driven
// from registered selects. A load-use hazard stalls ID for one cycle and
// puts a bubble into EX. A flush discards the instruction in ID.
//
// Optional build macro: STALL_CNT_EN adds a saturating 16-bit counter of
// load-use stall cycles. When the macro is undefined, stall_cnt is tied to 0.
module hazard_forward_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int NO_FWD_REG = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src,
    input  logic [ADDR_W-1:0]         id_dst,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      flush,
    output logic                      stall_id,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      ex_bubble,
    output logic [15:0]               stall_cnt
);

    localparam logic [ADDR_W-1:0] NO_FWD = ADDR_W'(NO_FWD_REG);

    // Shadow EX entry
    logic              ex_vld_q, ex_vld_d;
    logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic              ex_rw_q,  ex_rw_d;
    logic              ex_mr_q,  ex_mr_d;

    // Shadow MEM entry
    logic              mem_vld_q, mem_vld_d;
    logic [ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic              mem_rw_q,  mem_rw_d;

    logic [NUM_SRC*2-1:0] fwd_sel_q, fwd_sel_d;
    logic                 ex_bubble_q, ex_bubble_d;

    logic [NUM_SRC-1:0] match_ex;
    logic [NUM_SRC-1:0] match_mem;
    logic               load_use;
    logic               advance;

    // Compare each ID source against the EX and MEM producers. The excluded
    // register index never matches, so it can neither forward nor stall.
    always_comb begin
        match_ex  = '0;
        match_mem = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            match_ex[i]  = ex_vld_q && ex_rw_q && (ex_dst_q != NO_FWD) &&
                           (ex_dst_q == id_src[i*ADDR_W +: ADDR_W]);
            match_mem[i] = mem_vld_q && mem_rw_q && (mem_dst_q != NO_FWD) &&
                           (mem_dst_q == id_src[i*ADDR_W +: ADDR_W]);
        end
        load_use = ex_mr_q && (|match_ex);
        // Flush overrides stall: the instruction is being discarded anyway.
        stall_id = id_valid && !flush && load_use;
        advance  = !stall_id && !flush;
    end

    // Next-state for the shadow pipeline, bubble flag and forwarding selects
    always_comb begin
        ex_vld_d    = 1'b0;
        ex_dst_d    = id_dst;
        ex_rw_d     = id_regwrite;
        ex_mr_d     = id_memread;
        ex_bubble_d = 1'b1;
        fwd_sel_d   = '0;

        // The MEM entry always follows EX; nothing below ID ever halts.
        mem_vld_d = ex_vld_q;
        mem_dst_d = ex_dst_q;
        mem_rw_d  = ex_rw_q;

        if (advance) begin
            ex_vld_d    = id_valid;
            ex_bubble_d = !id_valid;
            // The current EX producer is in MEM next cycle, and the current
            // MEM producer is in WB. The younger producer (EX) wins.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (match_ex[i]) begin
                    fwd_sel_d[i*2 +: 2] = 2'b10;
                end else if (match_mem[i]) begin
                    fwd_sel_d[i*2 +: 2] = 2'b01;
                end else begin
                    fwd_sel_d[i*2 +: 2] = 2'b00;
                end
            end
        end
    end

    // Control state: valid bits, bubble flag and selects, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q    <= 1'b0;
            mem_vld_q   <= 1'b0;
            fwd_sel_q   <= '0;
            ex_bubble_q <= 1'b0;
        end else begin
            ex_vld_q    <= ex_vld_d;
            mem_vld_q   <= mem_vld_d;
            fwd_sel_q   <= fwd_sel_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    // Entry payload: only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        ex_dst_q  <= ex_dst_d;
        ex_rw_q   <= ex_rw_d;
        ex_mr_q   <= ex_mr_d;
        mem_dst_q <= mem_dst_d;
        mem_rw_q  <= mem_rw_d;
    end

    assign fwd_sel   = fwd_sel_q;
    assign ex_bubble = ex_bubble_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of load-use stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
